// File: rtl/safecrack_param_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : safecrack_param_fsm                                           |
// | Purpose  : Keypad safe controller. Matches debounced button presses      |
// |            against a CODE_LEN-digit passcode, counts wrong digits, holds |
// |            a timed lockout after MAX_ERRORS errors and allows passcode   |
// |            reprogramming while unlocked.                                 |
// | Ports    : clk        - system clock                                     |
// |            rst        - synchronous active-high reset                    |
// |            btn        - debounced button bus (one digit per press)       |
// |            ms         - password-change switch (level)                   |
// |            relock     - re-lock request (level)                          |
// |            unlocked   - safe is open                                     |
// |            prog_mode  - new passcode is being entered                    |
// |            locked_out - lockout timer running                            |
// |            err_leds   - thermometer of wrong-digit count                 |
// |            lock_leds  - thermometer of elapsed lockout seconds           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module safecrack_param_fsm #(
  parameter int BTN_W          = 4,
  parameter int CODE_LEN       = 3,
  parameter int MAX_ERRORS     = 3,
  parameter int LOCK_SECONDS   = 10,
  parameter int TICK_CYCLES    = 50_000_000,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter logic [CODE_LEN*BTN_W-1:0] DEFAULT_CODE = 12'h7DD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BTN_W-1:0]        btn,
  input  logic                    ms,
  input  logic                    relock,
  output logic                    unlocked,
  output logic                    prog_mode,
  output logic                    locked_out,
  output logic [MAX_ERRORS-1:0]   err_leds,
  output logic [LOCK_SECONDS-1:0] lock_leds
);

  localparam int IDX_W  = $clog2(CODE_LEN + 1);
  localparam int ERR_W  = $clog2(MAX_ERRORS + 1);
  localparam int SEC_W  = $clog2(LOCK_SECONDS + 1);
  localparam int TICK_W = $clog2(TICK_CYCLES + 1);

  localparam logic [BTN_W-1:0]  IDLE      = (BTN_ACTIVE_LOW != 0) ? {BTN_W{1'b1}} : {BTN_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CODE_LEN - 1);
  localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(MAX_ERRORS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(MAX_ERRORS);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(LOCK_SECONDS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ENTRY    = 2'd0,
    S_UNLOCKED = 2'd1,
    S_PROG     = 2'd2,
    S_LOCKOUT  = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [CODE_LEN*BTN_W-1:0]   code_q, code_d;
  logic [CODE_LEN*BTN_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [IDX_W-1:0]            pidx_q, pidx_d;
  logic [ERR_W-1:0]            err_q, err_d;
  logic [SEC_W-1:0]            sec_q, sec_d;
  logic [TICK_W-1:0]           tick_q, tick_d;
  logic [BTN_W-1:0]            btn_prev_q;

  logic                        unlocked_q, prog_mode_q, locked_out_q;
  logic [MAX_ERRORS-1:0]       err_leds_q, err_leds_d;
  logic [LOCK_SECONDS-1:0]     lock_leds_q, lock_leds_d;

  logic                        press;
  logic                        digit_ok;

  // A press is the idle-to-active transition only; holding a key or rolling
  // from one key straight onto another yields nothing.
  assign press = (btn != IDLE) && (btn_prev_q == IDLE);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    pidx_d   = pidx_q;
    err_d    = err_q;
    sec_d    = sec_q;
    tick_d   = tick_q;

    // Compare the pressed digit against the digit the entry index points at.
    digit_ok = 1'b0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if ((idx_q == IDX_W'(i)) && (btn == code_q[(CODE_LEN-1-i)*BTN_W +: BTN_W])) begin
        digit_ok = 1'b1;
      end
    end

    case (state_q)
      S_ENTRY: begin
        if (press) begin
          if (digit_ok) begin
            if (idx_q == IDX_LAST) begin
              state_d = S_UNLOCKED;
              idx_d   = '0;
              err_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            idx_d = '0;
            if (err_q == ERR_LAST) begin
              err_d   = ERR_MAX;
              state_d = S_LOCKOUT;
            end else begin
              err_d = err_q + ERR_W'(1);
            end
          end
        end
      end

      S_UNLOCKED: begin
        // relock wins over ms when both are raised together.
        if (relock) begin
          state_d = S_ENTRY;
          idx_d   = '0;
        end else if (ms) begin
          state_d = S_PROG;
          pidx_d  = '0;
        end
      end

      S_PROG: begin
        // Dropping ms abandons the new code; the live passcode is untouched
        // because only the shadow copy has been written so far.
        if (!ms) begin
          state_d = S_UNLOCKED;
        end else if (press) begin
          for (int i = 0; i < CODE_LEN; i++) begin
            if (pidx_q == IDX_W'(i)) begin
              shadow_d[(CODE_LEN-1-i)*BTN_W +: BTN_W] = btn;
            end
          end
          if (pidx_q == IDX_LAST) begin
            code_d  = shadow_d;
            state_d = S_ENTRY;
            idx_d   = '0;
            err_d   = '0;
            pidx_d  = '0;
          end else begin
            pidx_d = pidx_q + IDX_W'(1);
          end
        end
      end

      S_LOCKOUT: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (sec_q == SEC_LAST) begin
            state_d = S_ENTRY;
            sec_d   = '0;
            err_d   = '0;
            idx_d   = '0;
          end else begin
            sec_d = sec_q + SEC_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      default: begin
        state_d = S_ENTRY;
        idx_d   = '0;
        pidx_d  = '0;
        err_d   = '0;
        sec_d   = '0;
        tick_d  = '0;
      end
    endcase

    for (int k = 0; k < MAX_ERRORS; k++) begin
      err_leds_d[k] = (state_d == S_LOCKOUT) || (err_d > ERR_W'(k));
    end
    for (int k = 0; k < LOCK_SECONDS; k++) begin
      lock_leds_d[k] = (state_d == S_LOCKOUT) && (sec_d > SEC_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ENTRY;
      code_q       <= DEFAULT_CODE;
      shadow_q     <= DEFAULT_CODE;
      idx_q        <= '0;
      pidx_q       <= '0;
      err_q        <= '0;
      sec_q        <= '0;
      tick_q       <= '0;
      btn_prev_q   <= IDLE;
      unlocked_q   <= 1'b0;
      prog_mode_q  <= 1'b0;
      locked_out_q <= 1'b0;
      err_leds_q   <= '0;
      lock_leds_q  <= '0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      shadow_q     <= shadow_d;
      idx_q        <= idx_d;
      pidx_q       <= pidx_d;
      err_q        <= err_d;
      sec_q        <= sec_d;
      tick_q       <= tick_d;
      btn_prev_q   <= btn;
      unlocked_q   <= (state_d == S_UNLOCKED);
      prog_mode_q  <= (state_d == S_PROG);
      locked_out_q <= (state_d == S_LOCKOUT);
      err_leds_q   <= err_leds_d;
      lock_leds_q  <= lock_leds_d;
    end
  end

  assign unlocked   = unlocked_q;
  assign prog_mode  = prog_mode_q;
  assign locked_out = locked_out_q;
  assign err_leds   = err_leds_q;
  assign lock_leds  = lock_leds_q;

endmodule
`default_nettype wire

// File: tb/tb_safecrack_param_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_safecrack_param_fsm                                        |
// | Purpose  : Self-checking bench for safecrack_param_fsm (TICK_CYCLES=4).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_safecrack_param_fsm;

  localparam int TICKS = 4;
  localparam int LSEC  = 10;
  localparam logic [3:0] IDLE = 4'hF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = IDLE;
  logic       ms = 1'b0;
  logic       relock = 1'b0;
  logic       unlocked, prog_mode, locked_out;
  logic [2:0] err_leds;
  logic [9:0] lock_leds;

  safecrack_param_fsm #(
    .BTN_W(4), .CODE_LEN(3), .MAX_ERRORS(3), .LOCK_SECONDS(LSEC),
    .TICK_CYCLES(TICKS), .BTN_ACTIVE_LOW(1), .DEFAULT_CODE(12'h7DD)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .ms(ms), .relock(relock),
    .unlocked(unlocked), .prog_mode(prog_mode), .locked_out(locked_out),
    .err_leds(err_leds), .lock_leds(lock_leds)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  wire [15:0] dut_out = {unlocked, prog_mode, locked_out, err_leds, lock_leds};

  // ---------------- reference model (mode names, digit lists, cycle count)
  int         m_mode;      // 0 entry, 1 unlocked, 2 prog, 3 lockout
  logic [3:0] m_code[3];
  logic [3:0] m_new[$];
  int         m_pos, m_errs, m_elapsed;
  logic [3:0] m_prev;

  function automatic void model_reset();
    m_mode = 0; m_code[0] = 4'h7; m_code[1] = 4'hD; m_code[2] = 4'hD;
    m_new.delete(); m_pos = 0; m_errs = 0; m_elapsed = 0; m_prev = IDLE;
  endfunction

  function automatic void model_step(logic r, logic [3:0] b, logic m, logic rl);
    bit ev;
    if (r) begin model_reset(); return; end
    ev = (b != IDLE) && (m_prev == IDLE);
    m_prev = b;
    case (m_mode)
      0: if (ev) begin
        if (b == m_code[m_pos]) begin
          if (m_pos == 2) begin m_mode = 1; m_pos = 0; m_errs = 0; end
          else m_pos++;
        end else begin
          m_pos = 0; m_errs++;
          if (m_errs == 3) begin m_mode = 3; m_elapsed = 0; end
        end
      end
      1: if (rl) begin m_mode = 0; m_pos = 0; end
         else if (m) begin m_mode = 2; m_new.delete(); end
      2: if (!m) m_mode = 1;
         else if (ev) begin
           m_new.push_back(b);
           if (m_new.size() == 3) begin
             for (int i = 0; i < 3; i++) m_code[i] = m_new[i];
             m_mode = 0; m_pos = 0; m_errs = 0;
           end
         end
      default: begin
        m_elapsed++;
        if (m_elapsed == LSEC * TICKS) begin m_mode = 0; m_errs = 0; m_pos = 0; end
      end
    endcase
  endfunction

  function automatic logic [15:0] model_out();
    logic [2:0] e;
    logic [9:0] l;
    e = (m_mode == 3) ? 3'b111 : 3'((1 << m_errs) - 1);
    l = (m_mode == 3) ? 10'((1 << (m_elapsed / TICKS)) - 1) : 10'd0;
    return {m_mode == 1, m_mode == 2, m_mode == 3, e, l};
  endfunction

  // ---------------- checking helpers
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(logic r, logic [3:0] b, logic m, logic rl);
    rst = r; btn = b; ms = m; relock = rl;
    @(posedge clk);
    model_step(r, b, m, rl);
    #1;
    chk("model", dut_out, model_out());
  endtask

  task automatic press(logic [3:0] d);
    cycle(1'b0, d, ms, relock);
    cycle(1'b0, IDLE, ms, relock);
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic       r;
    logic [3:0] b;
    logic       m;
    logic       rl;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic r, logic [3:0] b, logic m, logic rl,
                              logic u, logic p, logic lo, logic [2:0] e);
    vec_t v;
    v.r = r; v.b = b; v.m = m; v.rl = rl; v.exp = {u, p, lo, e, 10'd0};
    vecs.push_back(v);
  endfunction

  int lo_cnt;
  logic [3:0] digs[5] = '{4'h7, 4'hD, 4'hB, 4'hE, 4'h0};

  initial begin
    model_reset();
    // reset, then unlock with 7 D D
    add(1, IDLE, 0, 0, 0, 0, 0, 3'b000);
    add(0, IDLE, 0, 0, 0, 0, 0, 3'b000);
    add(0, 4'h7, 0, 0, 0, 0, 0, 3'b000);
    add(0, IDLE, 0, 0, 0, 0, 0, 3'b000);
    add(0, 4'hD, 0, 0, 0, 0, 0, 3'b000);
    add(0, IDLE, 0, 0, 0, 0, 0, 3'b000);
    add(0, 4'hD, 0, 0, 1, 0, 0, 3'b000);
    add(0, IDLE, 0, 0, 1, 0, 0, 3'b000);
    add(0, IDLE, 0, 1, 0, 0, 0, 3'b000);
    // held 7 is one event; rolling onto E is no event; next 7 is wrong
    for (int i = 0; i < 20; i++) add(0, 4'h7, 0, 0, 0, 0, 0, 3'b000);
    add(0, 4'hE, 0, 0, 0, 0, 0, 3'b000);
    add(0, IDLE, 0, 0, 0, 0, 0, 3'b000);
    add(0, 4'h7, 0, 0, 0, 0, 0, 3'b001);
    add(0, IDLE, 0, 0, 0, 0, 0, 3'b001);
    add(0, 4'hE, 0, 0, 0, 0, 0, 3'b011);
    add(0, IDLE, 0, 0, 0, 0, 0, 3'b011);
    add(0, 4'hE, 0, 0, 0, 0, 1, 3'b111);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].b, vecs[i].m, vecs[i].rl);
      chk($sformatf("vec%0d", i), dut_out, vecs[i].exp);
    end

    // lockout length and LED fill; presses during lockout are ignored
    lo_cnt = 1;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, (i % 2) ? IDLE : 4'h7, 1'b1, 1'b1);
      if (!locked_out) break;
      lo_cnt++;
      if (lo_cnt == 21) chk("lock_leds_mid", {6'd0, lock_leds}, 16'h001F);
      if (lo_cnt == 40) chk("lock_leds_last", {6'd0, lock_leds}, 16'h01FF);
    end
    chk("lockout_len", 16'(lo_cnt), 16'd40);
    chk("after_lockout", dut_out, 16'h0000);
    ms = 1'b0; relock = 1'b0;
    cycle(1'b0, IDLE, 1'b0, 1'b0);

    // abort programming: old code stays valid
    press(4'h7); press(4'hD); press(4'hD);
    ms = 1'b1; press(4'hB);
    chk("prog_active", {15'd0, prog_mode}, 16'd1);
    ms = 1'b0; cycle(1'b0, IDLE, 1'b0, 1'b0);
    chk("abort_unlocked", dut_out, 16'h8000);
    // relock beats ms
    cycle(1'b0, IDLE, 1'b1, 1'b1);
    chk("relock_prio", dut_out, 16'h0000);
    ms = 1'b0; relock = 1'b0;
    press(4'h7); press(4'hD); press(4'hD);
    chk("old_code_ok", dut_out, 16'h8000);

    // reprogram to B B E
    ms = 1'b1; cycle(1'b0, IDLE, 1'b1, 1'b0);
    press(4'hB); press(4'hB); press(4'hE);
    ms = 1'b0; cycle(1'b0, IDLE, 1'b0, 1'b0);
    press(4'h7);
    chk("old_code_fails", dut_out, 16'h0400);
    press(4'hB); press(4'hB); press(4'hE);
    chk("new_code_ok", dut_out, 16'h8000);

    // reset during PROG restores default code
    ms = 1'b1; cycle(1'b0, IDLE, 1'b1, 1'b0); press(4'h7);
    cycle(1'b1, IDLE, 1'b1, 1'b0);
    chk("rst_prog", dut_out, 16'h0000);
    ms = 1'b0;
    press(4'h7); press(4'hD); press(4'hD);
    chk("default_after_rst", dut_out, 16'h8000);
    relock = 1'b1; cycle(1'b0, IDLE, 1'b0, 1'b1); relock = 1'b0;

    // reset during LOCKOUT
    press(4'hE); press(4'hE); press(4'hE);
    for (int i = 0; i < 7; i++) cycle(1'b0, IDLE, 1'b0, 1'b0);
    cycle(1'b1, IDLE, 1'b0, 1'b0);
    chk("rst_lockout", dut_out, 16'h0000);

    // randomized phase against the model
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] b;
      logic m, rl, r;
      b  = ($urandom_range(0, 2) == 0) ? digs[$urandom_range(0, 4)] : IDLE;
      m  = ($urandom_range(0, 9) == 0) ? ~ms : ms;
      rl = ($urandom_range(0, 15) == 0);
      r  = ($urandom_range(0, 699) == 0);
      cycle(r, b, m, rl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
